archer_projectile_ctrl: RTL and testbench



---
 rtl/archer_projectile_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_archer_projectile_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/archer_projectile_ctrl.sv
// Archer projectile slot manager: spawns shots on fire requests under a per-frame
// cooldown and, once per frame, walks every live slot to move or retire it.
module archer_projectile_ctrl #(
  parameter int PROJECTILE_COUNT = 4,
  parameter int PROJ_SPEED       = 4,
  parameter int FIRE_COOLDOWN    = 20,
  parameter int X_MAX            = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           fire_req,
  input  logic [11:0]                    spawn_x,
  input  logic [11:0]                    spawn_y,
  input  logic                           flip_hor_archer,
  input  logic [1:0]                     game_active,
  input  logic [1:0]                     char_class,
  input  logic                           alive,
  input  logic [PROJECTILE_COUNT-1:0]    hit_clear,
  output logic [PROJECTILE_COUNT*12-1:0] pos_x_proj,
  output logic [PROJECTILE_COUNT*12-1:0] pos_y_proj,
  output logic [PROJECTILE_COUNT-1:0]    projectile_animated,
  output logic [PROJECTILE_COUNT-1:0]    proj_dir,
  output logic                           fire_ack,
  output logic                           cooldown_busy
);

  localparam int IDX_W = (PROJECTILE_COUNT > 1) ? $clog2(PROJECTILE_COUNT) : 1;
  localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROJECTILE_COUNT - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(FIRE_COOLDOWN);
  localparam logic [11:0]      SPEED_12 = 12'(PROJ_SPEED);
  localparam logic [12:0]      SPEED_13 = 13'(PROJ_SPEED);
  localparam logic [12:0]      XMAX_13  = 13'(X_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SPAWN  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            w_idx_next;
  logic [IDX_W-1:0]            w_free_idx;
  logic [CD_W-1:0]             r_cooldown;
  logic [CD_W-1:0]             w_cooldown_next;
  logic                        r_cooldown_busy;
  logic [PROJECTILE_COUNT-1:0] r_mask;
  logic [PROJECTILE_COUNT-1:0] w_mask_next;
  logic                        w_enable;
  logic                        w_any_free;
  logic                        w_spawn;

  assign w_enable = (game_active != 2'd0) && (char_class == 2'd2) && alive;

  // Lowest-index free slot: scan downward so the smallest free index is written last.
  always_comb begin
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = PROJECTILE_COUNT - 1; i >= 0; i--) begin
      if (!r_mask[i]) begin
        w_free_idx = IDX_W'(i);
        w_any_free = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_spawn      = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_state_next = UPDATE;
          w_idx_next   = '0;
        end
      end
      UPDATE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = SPAWN;
        end else begin
          w_idx_next = r_idx + IDX_W'(1);
        end
      end
      SPAWN: begin
        w_state_next = IDLE;
        w_spawn      = w_enable && fire_req && (r_cooldown == '0) && w_any_free;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_cooldown_next = r_cooldown;
    if (!w_enable) begin
      w_cooldown_next = '0;
    end else if (w_spawn) begin
      w_cooldown_next = CD_LOAD;
    end else if ((r_state == SPAWN) && (r_cooldown != '0)) begin
      w_cooldown_next = r_cooldown - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_cooldown      <= '0;
      r_cooldown_busy <= 1'b0;
      r_mask          <= '0;
    end else begin
      r_state         <= w_state_next;
      r_idx           <= w_idx_next;
      r_cooldown      <= w_cooldown_next;
      r_cooldown_busy <= (w_cooldown_next != '0);
      r_mask          <= w_mask_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PROJECTILE_COUNT; gi++) begin : g_slot
      logic [11:0] r_x;
      logic [11:0] r_y;
      logic        r_dir;
      logic [11:0] w_x_moved;
      logic        w_retire;
      logic        w_upd_sel;
      logic        w_spawn_here;

      assign w_upd_sel    = (r_state == UPDATE) && (r_idx == IDX_W'(gi)) && r_mask[gi];
      assign w_spawn_here = w_spawn && (w_free_idx == IDX_W'(gi));

      // Right-edge test widened to 13 bits so x near 4095 cannot wrap past X_MAX.
      always_comb begin
        w_retire  = 1'b0;
        w_x_moved = r_x;
        if (r_dir) begin
          if (r_x < SPEED_12) begin
            w_retire = 1'b1;
          end else begin
            w_x_moved = r_x - SPEED_12;
          end
        end else begin
          if (({1'b0, r_x} + SPEED_13) > XMAX_13) begin
            w_retire = 1'b1;
          end else begin
            w_x_moved = r_x + SPEED_12;
          end
        end
      end

      // A kill pulse overrides any same-cycle spawn or move on this slot.
      assign w_mask_next[gi] = w_enable && !hit_clear[gi] &&
                               (w_spawn_here || (r_mask[gi] && !(w_upd_sel && w_retire)));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_x   <= '0;
          r_y   <= '0;
          r_dir <= 1'b0;
        end else if (!hit_clear[gi]) begin
          if (w_spawn_here) begin
            r_x   <= spawn_x;
            r_y   <= spawn_y;
            r_dir <= flip_hor_archer;
          end else if (w_upd_sel && !w_retire) begin
            r_x <= w_x_moved;
          end
        end
      end

      assign pos_x_proj[gi*12 +: 12] = r_x;
      assign pos_y_proj[gi*12 +: 12] = r_y;
      assign proj_dir[gi]            = r_dir;
    end
  endgenerate

  assign projectile_animated = r_mask;
  assign cooldown_busy       = r_cooldown_busy;
  assign fire_ack            = w_spawn && !rst;

endmodule

// File: tb/tb_archer_projectile_ctrl.sv
// Bench for archer_projectile_ctrl: directed scenarios followed by randomized frames,
// all checked against a frame-level model of slots, cooldown and spawn rules.
module tb_archer_projectile_ctrl;

  localparam int N     = 4;
  localparam int SPEED = 4;
  localparam int CD    = 20;
  localparam int XMAX  = 1023;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic            fire_req;
  logic [11:0]     spawn_x;
  logic [11:0]     spawn_y;
  logic            flip_hor_archer;
  logic [1:0]      game_active;
  logic [1:0]      char_class;
  logic            alive;
  logic [N-1:0]    hit_clear;
  logic [N*12-1:0] pos_x_proj;
  logic [N*12-1:0] pos_y_proj;
  logic [N-1:0]    projectile_animated;
  logic [N-1:0]    proj_dir;
  logic            fire_ack;
  logic            cooldown_busy;

  always #5 clk = ~clk;

  archer_projectile_ctrl #(
    .PROJECTILE_COUNT(N),
    .PROJ_SPEED      (SPEED),
    .FIRE_COOLDOWN   (CD),
    .X_MAX           (XMAX)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_tick         (frame_tick),
    .fire_req           (fire_req),
    .spawn_x            (spawn_x),
    .spawn_y            (spawn_y),
    .flip_hor_archer    (flip_hor_archer),
    .game_active        (game_active),
    .char_class         (char_class),
    .alive              (alive),
    .hit_clear          (hit_clear),
    .pos_x_proj         (pos_x_proj),
    .pos_y_proj         (pos_y_proj),
    .projectile_animated(projectile_animated),
    .proj_dir           (proj_dir),
    .fire_ack           (fire_ack),
    .cooldown_busy      (cooldown_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_x [N];
  int m_y [N];
  bit m_dir [N];
  bit m_live [N];
  int m_cd;
  bit obs_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_enable();
    return (game_active != 2'd0) && (char_class == 2'd2) && alive;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_live[i] = 1'b0;
    m_cd = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dir[i] = 1'b0; m_live[i] = 1'b0;
    end
    m_cd = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] em;
    for (int i = 0; i < N; i++) em[i] = m_live[i];
    check("mask", projectile_animated, em);
    check("busy", cooldown_busy, (m_cd != 0));
    check("ack_quiet", fire_ack, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (m_live[i]) begin
        check($sformatf("x%0d", i), pos_x_proj[i*12 +: 12], m_x[i]);
        check($sformatf("y%0d", i), pos_y_proj[i*12 +: 12], m_y[i]);
        check($sformatf("dir%0d", i), proj_dir[i], m_dir[i]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; hit_clear = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n, input bit chk_ack);
    repeat (n) begin
      @(negedge clk);
      if (!model_enable()) model_clear();
      if (chk_ack) check("idle_ack", fire_ack, 1'b0);
    end
  endtask

  task automatic hit_idle(input logic [N-1:0] hm);
    @(negedge clk);
    if (!model_enable()) model_clear();
    hit_clear = hm;
    @(negedge clk);
    hit_clear = '0;
    for (int i = 0; i < N; i++) if (hm[i]) m_live[i] = 1'b0;
    if (!model_enable()) model_clear();
  endtask

  // One full frame; hk selects the UPDATE cycle carrying hit mask hm (-1 = none).
  task automatic frame(input logic [N-1:0] hm, input int hk);
    bit en;
    bit exp_ack;
    int ff;
    en = model_enable();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == hk) hit_clear = hm;
      @(negedge clk);
      hit_clear = '0;
    end
    exp_ack = 1'b0;
    if (!en) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_live[i]) begin
          if (m_dir[i]) begin
            if (m_x[i] < SPEED) m_live[i] = 1'b0;
            else m_x[i] = m_x[i] - SPEED;
          end else begin
            if (m_x[i] + SPEED > XMAX) m_live[i] = 1'b0;
            else m_x[i] = m_x[i] + SPEED;
          end
        end
        if (hk >= 0 && hm[i]) m_live[i] = 1'b0;
      end
      ff = -1;
      for (int i = 0; i < N; i++) if (!m_live[i] && ff < 0) ff = i;
      if (fire_req && m_cd == 0 && ff >= 0) begin
        exp_ack = 1'b1;
        m_x[ff] = int'(spawn_x); m_y[ff] = int'(spawn_y);
        m_dir[ff] = flip_hor_archer; m_live[ff] = 1'b1;
        m_cd = CD;
      end else if (m_cd > 0) begin
        m_cd--;
      end
    end
    obs_ack = fire_ack;
    check("spawn_ack", obs_ack, exp_ack);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int f1;
    int f2;
    int nf;
    rst = 1'b1; frame_tick = 1'b0; fire_req = 1'b0;
    spawn_x = '0; spawn_y = '0; flip_hor_archer = 1'b0;
    game_active = 2'd1; char_class = 2'd2; alive = 1'b1; hit_clear = '0;

    // Reset state and quiet idle
    do_reset();
    check("rst_mask", projectile_animated, '0);
    check("rst_posx", pos_x_proj, '0);
    check("rst_posy", pos_y_proj, '0);
    check("rst_dir", proj_dir, '0);
    check("rst_ack", fire_ack, 1'b0);
    check("rst_busy", cooldown_busy, 1'b0);
    idle(100, 1'b1);
    check("idle_mask", projectile_animated, '0);
    check("idle_posx", pos_x_proj, '0);

    // Single spawn and one move
    spawn_x = 12'd500; spawn_y = 12'd300; flip_hor_archer = 1'b0; fire_req = 1'b1;
    frame('0, -1);
    check("single_ack", obs_ack, 1'b1);
    fire_req = 1'b0;
    frame('0, -1);
    check("single_x504", pos_x_proj[11:0], 12'd504);
    check("single_busy", cooldown_busy, 1'b1);

    // Cooldown spacing
    do_reset();
    fire_req = 1'b1;
    acks = 0; f1 = -1; f2 = -1;
    for (int f = 1; f <= 25; f++) begin
      frame('0, -1);
      if (obs_ack) begin
        acks++;
        if (f1 < 0) f1 = f; else if (f2 < 0) f2 = f;
      end
    end
    check("cd_spawns", acks, 2);
    check("cd_gap", f2 - f1, 21);
    check("cd_mask", projectile_animated, 4'b0011);

    // Left exit
    do_reset();
    flip_hor_archer = 1'b1; spawn_x = 12'd6; spawn_y = 12'd40; fire_req = 1'b1;
    frame('0, -1);
    fire_req = 1'b0;
    frame('0, -1);
    check("left_x2", pos_x_proj[11:0], 12'd2);
    frame('0, -1);
    check("left_retired", projectile_animated[0], 1'b0);
    check("left_keep_x", pos_x_proj[11:0], 12'd2);

    // Right exit
    do_reset();
    flip_hor_archer = 1'b0; spawn_x = 12'd1020; fire_req = 1'b1;
    frame('0, -1);
    check("right_live", projectile_animated[0], 1'b1);
    fire_req = 1'b0;
    frame('0, -1);
    check("right_retired", projectile_animated[0], 1'b0);

    // Fill all slots, refuse when full, kill slot 1 mid-update, reuse it
    do_reset();
    spawn_x = 12'd100; spawn_y = 12'd50; fire_req = 1'b1;
    acks = 0; nf = 0;
    while (acks < N && nf < 100) begin
      frame('0, -1);
      if (obs_ack) acks++;
      nf++;
    end
    check("fill_spawns", acks, N);
    acks = 0;
    for (int f = 0; f < 25; f++) begin
      frame('0, -1);
      if (obs_ack) acks++;
    end
    check("full_no_ack", acks, 0);
    fire_req = 1'b0;
    frame(4'b0010, 1);
    check("kill_slot1", projectile_animated, 4'b1101);
    spawn_x = 12'd777; fire_req = 1'b1;
    frame('0, -1);
    check("reuse_ack", obs_ack, 1'b1);
    check("reuse_x", pos_x_proj[12 +: 12], 12'd777);
    check("reuse_mask", projectile_animated, 4'b1111);

    // Disable through char_class
    char_class = 2'd1;
    idle(1, 1'b0);
    check("disable_mask", projectile_animated, '0);
    check("disable_busy", cooldown_busy, 1'b0);
    char_class = 2'd2;
    fire_req = 1'b0;
    idle(2, 1'b0);

    // Randomized frames
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0:       spawn_x = 12'($urandom_range(0, 8));
        1:       spawn_x = 12'($urandom_range(1012, 1023));
        2:       spawn_x = 12'($urandom_range(0, 1023));
        default: spawn_x = 12'($urandom_range(0, 4095));
      endcase
      spawn_y         = 12'($urandom_range(0, 4095));
      flip_hor_archer = 1'($urandom_range(0, 1));
      fire_req        = ($urandom_range(0, 9) < 7);
      game_active     = ($urandom_range(0, 14) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      char_class      = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      alive           = ($urandom_range(0, 14) != 0);
      if ($urandom_range(0, 4) == 0) frame(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, N - 1)));
      else frame('0, -1);
      if ($urandom_range(0, 7) == 0) hit_idle(N'($urandom_range(1, (1 << N) - 1)));
      idle(int'($urandom_range(0, 3)), 1'b1);
    end
    game_active = 2'd1; char_class = 2'd2; alive = 1'b1; fire_req = 1'b0;
    idle(1, 1'b0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
